// File: rtl/apb4_to_sram_pkg.sv
// Shared types and constants for the APB4-to-SRAM bridge.
package apb_sram_pkg;

  localparam int RD_LATENCY_MAX = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_CAP,
    RESP,
    ERR
  } bridge_state_t;

  // Number of byte-offset bits below the word index; 0 for byte-wide data.
  function automatic int byte_align(input int data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb4_to_sram_if.sv
// APB4 bus segment between the interconnect (master) and the bridge (slave).
interface apb4_to_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb4_to_sram_addr_check.sv
// Address decode: byte address -> SRAM word index plus a combined error flag
// covering out-of-range, misaligned and (optionally) non-secure accesses.
module apb_sram_addr_check
  import apb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int SECURE_ONLY = 0,
  parameter int SA_W        = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  output logic [SA_W-1:0]       word_idx,
  output logic                  err
);

  localparam int AL = byte_align(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AL_MASK = (ADDR_WIDTH'(1) << AL) - ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  range_err;
  logic                  align_err;
  logic                  sec_err;
  logic                  unused_prot;

  // Full-width index so upper address bits can never alias onto a valid word.
  assign idx_full    = paddr >> AL;
  assign range_err   = 64'(idx_full) >= 64'(MEM_DEPTH);
  assign align_err   = |(paddr & AL_MASK);
  assign sec_err     = (SECURE_ONLY != 0) && pprot[1];
  assign err         = range_err | align_err | sec_err;
  assign word_idx    = idx_full[SA_W-1:0];
  assign unused_prot = ^{pprot[2], pprot[0]};

endmodule

// File: rtl/apb4_to_sram.sv
// APB4 completer driving a synchronous single-port SRAM. Byte-lane writes,
// configurable read latency, range/alignment/security error responses.
// Every APB and SRAM output comes straight from a flop.
module apb4_to_sram
  import apb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int SECURE_ONLY = 0,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int SA_W   = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  apb4_to_sram_if.slave         apb,
  output logic [SA_W-1:0]       SRAM_ADDR,
  output logic                  SRAM_CE,
  output logic [STRB_W-1:0]     SRAM_WE,
  output logic                  SRAM_OE,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
);

  localparam int CNT_W = $clog2(RD_LATENCY_MAX);

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_dw_chk
      $error("apb4_to_sram: DATA_WIDTH must be a multiple of 8 and >= 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_lat_chk
      $error("apb4_to_sram: RD_LATENCY out of range 1..RD_LATENCY_MAX");
    end
  endgenerate

  bridge_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [SA_W-1:0]       addr_q, addr_d;
  logic                  ce_q, ce_d;
  logic [STRB_W-1:0]     we_q, we_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SA_W-1:0]       word_idx;
  logic                  dec_err;
  logic                  setup;

  apb_sram_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .SECURE_ONLY(SECURE_ONLY),
    .SA_W       (SA_W)
  ) u_chk (
    .paddr   (apb.PADDR),
    .pprot   (apb.PPROT),
    .word_idx(word_idx),
    .err     (dec_err)
  );

  assign setup = apb.PSEL && !apb.PENABLE;

  // Next-state and next-output decode; strobes default to inactive each cycle.
  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    addr_d    = addr_q;
    ce_d      = 1'b1;
    we_d      = '0;
    oe_d      = 1'b1;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (setup) begin
          if (dec_err) begin
            state_d = ERR;
          end else if (apb.PWRITE) begin
            state_d = WRITE;
            addr_d  = word_idx;
            wdata_d = apb.PWDATA;
            we_d    = apb.PSTRB;
            // An all-zero strobe completes on the bus without touching the macro.
            ce_d    = ~|apb.PSTRB;
          end else begin
            state_d = RD_WAIT;
            addr_d  = word_idx;
            ce_d    = 1'b0;
            oe_d    = 1'b0;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      WRITE: begin
        state_d  = RESP;
        pready_d = 1'b1;
      end
      RD_WAIT: begin
        oe_d = 1'b0;
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RD_CAP: begin
        prdata_d = SRAM_RDATA;
        pready_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      ERR: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
        prdata_d  = '0;
        state_d   = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Master dropped PSEL mid-transfer: abandon it and release the SRAM.
    if (state_q != IDLE && !apb.PSEL) begin
      state_d   = IDLE;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      ce_d      = 1'b1;
      we_d      = '0;
      oe_d      = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      addr_q    <= '0;
      ce_q      <= 1'b1;
      we_q      <= '0;
      oe_q      <= 1'b1;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      addr_q    <= addr_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE     = ce_q;
  assign SRAM_WE     = we_q;
  assign SRAM_OE     = oe_q;
  assign SRAM_WDATA  = wdata_q;

endmodule

// File: tb/tb_apb4_to_sram.sv
// Directed bench: two bridge instances (A: 40-bit address, 1000 words,
// latency 1; B: 32-bit address, 1024 words, latency 3, secure-only), each
// backed by a behavioural SRAM.
module tb_apb4_to_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [39:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  apb4_to_sram_if #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) ifa ();
  apb4_to_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  assign ifa.PSEL = psel_a;  assign ifb.PSEL = psel_b;
  assign ifa.PENABLE = penable; assign ifb.PENABLE = penable;
  assign ifa.PWRITE = pwrite;   assign ifb.PWRITE = pwrite;
  assign ifa.PADDR = paddr;     assign ifb.PADDR = paddr[31:0];
  assign ifa.PWDATA = pwdata;   assign ifb.PWDATA = pwdata;
  assign ifa.PSTRB = pstrb;     assign ifb.PSTRB = pstrb;
  assign ifa.PPROT = pprot;     assign ifb.PPROT = pprot;

  logic [9:0]  sa_a, sa_b;
  logic        ce_a, ce_b, oe_a, oe_b;
  logic [3:0]  we_a, we_b;
  logic [31:0] wd_a, wd_b, rd_a;
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_b [0:2];
  int          strb_cnt_a = 0, strb_cnt_b = 0, ce_cnt_b = 0;

  apb4_to_sram #(.ADDR_WIDTH(40), .DATA_WIDTH(32), .MEM_DEPTH(1000),
                 .RD_LATENCY(1), .SECURE_ONLY(0)) u_a (
    .CLK(clk), .RST(rst), .apb(ifa.slave), .SRAM_ADDR(sa_a), .SRAM_CE(ce_a),
    .SRAM_WE(we_a), .SRAM_OE(oe_a), .SRAM_WDATA(wd_a), .SRAM_RDATA(rd_a));

  apb4_to_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                 .RD_LATENCY(3), .SECURE_ONLY(1)) u_b (
    .CLK(clk), .RST(rst), .apb(ifb.slave), .SRAM_ADDR(sa_b), .SRAM_CE(ce_b),
    .SRAM_WE(we_b), .SRAM_OE(oe_b), .SRAM_WDATA(wd_b), .SRAM_RDATA(pipe_b[2]));

  // SRAM A: one-cycle read, byte-lane writes, strobe activity counter.
  always @(posedge clk) begin
    if (!ce_a || we_a != 4'h0 || !oe_a) strb_cnt_a <= strb_cnt_a + 1;
    if (!ce_a) begin
      if (we_a != 4'h0) begin
        for (int i = 0; i < 4; i++) if (we_a[i]) mem_a[sa_a][i*8 +: 8] <= wd_a[i*8 +: 8];
      end else rd_a <= mem_a[sa_a];
    end
  end

  // SRAM B: three-cycle read pipeline, plus CE-low cycle counter.
  always @(posedge clk) begin
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (!ce_b || we_b != 4'h0 || !oe_b) strb_cnt_b <= strb_cnt_b + 1;
    if (!ce_b) begin
      ce_cnt_b <= ce_cnt_b + 1;
      if (we_b != 4'h0) begin
        for (int i = 0; i < 4; i++) if (we_b[i]) mem_b[sa_b][i*8 +: 8] <= wd_b[i*8 +: 8];
      end else pipe_b[0] <= mem_b[sa_b];
    end
  end

  // One APB transfer; starts and ends 1 time unit after a rising edge.
  task automatic apb_xfer(input bit b, input bit wr, input logic [39:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                          output int lat, output logic [31:0] rd, output logic er);
    psel_a = !b; psel_b = b; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge clk); #1 penable = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!(b ? ifb.PREADY : ifa.PREADY) && lat < 20);
    if (!(b ? ifb.PREADY : ifa.PREADY)) begin
      checks++; errors++;
      $display("FAIL timeout: no PREADY after %0d cycles, addr=%h", lat, addr);
    end
    rd = b ? ifb.PRDATA : ifa.PRDATA;
    er = b ? ifb.PSLVERR : ifa.PSLVERR;
    @(posedge clk); #1 psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.PRDATA, ifa.PREADY, ifa.PSLVERR, sa_a, ce_a, we_a, oe_a, wd_a} !==
        {32'h0, 1'b0, 1'b0, 10'h0, 1'b1, 4'h0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_a: pready=%b ce=%b oe=%b we=%h", ifa.PREADY, ce_a, oe_a, we_a);
    end
    checks++;
    if ({ifb.PRDATA, ifb.PREADY, ifb.PSLVERR, sa_b, ce_b, we_b, oe_b, wd_b} !==
        {32'h0, 1'b0, 1'b0, 10'h0, 1'b1, 4'h0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_b: pready=%b ce=%b oe=%b we=%h", ifb.PREADY, ce_b, oe_b, we_b);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1, 40'h10, 32'hDEADBEEF, 4'hF, 3'b000, lat, rd, er);
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL wr_basic: lat=%0d err=%b, want 2/0", lat, er);
    end
    apb_xfer(0, 0, 40'h10, 32'h0, 4'hF, 3'b000, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL rd_basic: lat=%0d data=%h err=%b, want 3/deadbeef/0", lat, rd, er);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic er; int s0;
    apb_xfer(0, 1, 40'h10, 32'h11223344, 4'b0101, 3'b000, lat, rd, er);
    apb_xfer(0, 0, 40'h10, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      errors++; $display("FAIL byte_lane: data=%h err=%b, want de22be44/0", rd, er);
    end
    s0 = strb_cnt_a;
    apb_xfer(0, 1, 40'h10, 32'hFFFFFFFF, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (strb_cnt_a != s0 || lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL zero_strb: strobes=%0d lat=%0d err=%b, want 0/2/0", strb_cnt_a - s0, lat, er);
    end
    apb_xfer(0, 0, 40'h10, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++; $display("FAIL zero_strb_rd: data=%h want de22be44", rd);
    end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er; int s0;
    apb_xfer(0, 1, 40'hF9C, 32'hA5A5A5A5, 4'hF, 3'b000, lat, rd, er);
    apb_xfer(0, 0, 40'hF9C, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL last_word: data=%h err=%b, want a5a5a5a5/0", rd, er);
    end
    s0 = strb_cnt_a;
    apb_xfer(0, 0, 40'hFA0, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL over_range: err=%b data=%h lat=%0d, want 1/0/2", er, rd, lat);
    end
    apb_xfer(0, 1, 40'h1_0000_0010, 32'h0BADF00D, 4'hF, 3'b000, lat, rd, er);
    checks++;
    if (er !== 1'b1 || mem_a[4] !== 32'hDE22BE44) begin
      errors++; $display("FAIL upper_bits: err=%b word4=%h, want 1/de22be44", er, mem_a[4]);
    end
    apb_xfer(0, 1, 40'h12, 32'h0BADF00D, 4'hF, 3'b000, lat, rd, er);
    checks++;
    if (er !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL misalign: err=%b lat=%0d, want 1/2", er, lat);
    end
    checks++;
    if (strb_cnt_a != s0) begin
      errors++; $display("FAIL err_strobe: strobe cycles=%0d want 0", strb_cnt_a - s0);
    end
  endtask

  task automatic test_latency3();
    int lat; logic [31:0] rd; logic er; int c0;
    apb_xfer(1, 1, 40'h20, 32'hCAFEF00D, 4'hF, 3'b000, lat, rd, er);
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL b_write: lat=%0d err=%b, want 2/0", lat, er);
    end
    c0 = ce_cnt_b;
    apb_xfer(1, 0, 40'h20, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (lat !== 5 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("FAIL lat3_read: lat=%0d data=%h err=%b, want 5/cafef00d/0", lat, rd, er);
    end
    checks++;
    if (ce_cnt_b - c0 != 1) begin
      errors++; $display("FAIL lat3_ce: ce low cycles=%0d want 1", ce_cnt_b - c0);
    end
  endtask

  task automatic test_secure();
    int lat; logic [31:0] rd; logic er; int s0;
    s0 = strb_cnt_b;
    apb_xfer(1, 1, 40'h20, 32'h12345678, 4'hF, 3'b010, lat, rd, er);
    checks++;
    if (er !== 1'b1 || lat !== 2 || strb_cnt_b != s0 || mem_b[8] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL nonsecure: err=%b lat=%0d word8=%h, want 1/2/cafef00d", er, lat, mem_b[8]);
    end
    apb_xfer(1, 0, 40'h20, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL secure_rd: err=%b data=%h, want 0/cafef00d", er, rd);
    end
  endtask

  task automatic test_reset_mid();
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 40'h20; pprot = 3'b000;
    @(posedge clk); #1 penable = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({ifb.PRDATA, ifb.PREADY, ifb.PSLVERR, sa_b, ce_b, we_b, oe_b, wd_b} !==
        {32'h0, 1'b0, 1'b0, 10'h0, 1'b1, 4'h0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_mid: prdata=%h ce=%b oe=%b sa=%h", ifb.PRDATA, ce_b, oe_b, sa_b);
    end
    @(posedge clk); #1 rst = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1, 40'h40, 32'h55AA1234, 4'hF, 3'b000, lat, rd, er);
    apb_xfer(0, 0, 40'h40, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (rd !== 32'h55AA1234 || lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL b2b_rd1: data=%h lat=%0d err=%b, want 55aa1234/3/0", rd, lat, er);
    end
    apb_xfer(0, 0, 40'h10, 32'h0, 4'h0, 3'b000, lat, rd, er);
    checks++;
    if (rd !== 32'hDE22BE44 || lat !== 3) begin
      errors++; $display("FAIL b2b_rd2: data=%h lat=%0d, want de22be44/3", rd, lat);
    end
  endtask

  task automatic test_protocol();
    int s0; bit bad;
    s0 = strb_cnt_a; bad = 0;
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 40'h80; pstrb = 4'hF;
    repeat (3) begin
      @(negedge clk); if (ifa.PREADY) bad = 1;
    end
    checks++;
    if (bad || strb_cnt_a != s0) begin
      errors++; $display("FAIL penable_idle: pready_seen=%b strobes=%0d, want 0/0", bad, strb_cnt_a - s0);
    end
    @(posedge clk); #1 penable = 1'b0;
    @(posedge clk); #1 psel_a = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ce_a !== 1'b1 || we_a !== 4'h0 || ifa.PREADY !== 1'b0) begin
      errors++; $display("FAIL abort: ce=%b we=%h pready=%b, want 1/0/0", ce_a, we_a, ifa.PREADY);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_range();
    test_latency3();
    test_secure();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
